// File: rtl/pmt_pack_pkg.sv
// Shared types and widths for the PMT receive word packer.
package pmt_pack_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned WORD_W = DATA_W * LANES;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned DROP_W = 16;

  localparam logic [DROP_W-1:0] DROP_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAD   = 2'd2,
    TRAIL = 2'd3
  } state_t;

  // Trailer layout, MSB first: [127:96] magic, [95:64] word count,
  // [63:48] reserved, [47:32] drop count, [31:0] frame index.
  typedef struct packed {
    logic [DATA_W-1:0] magic;
    logic [CNT_W-1:0]  word_cnt;
    logic [15:0]       rsvd;
    logic [DROP_W-1:0] drop_cnt;
    logic [CNT_W-1:0]  frame_idx;
  } trailer_t;

  function automatic logic [DROP_W-1:0] drop_add(input logic [DROP_W-1:0] cnt,
                                                 input logic [2:0] inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, cnt} + (DROP_W+1)'(inc);
    return (sum > {1'b0, DROP_CNT_MAX}) ? DROP_CNT_MAX : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/pmt_pack_slot.sv
// Single-entry holding register between the packer and the DMA write FIFO.
module pmt_pack_slot
  import pmt_pack_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic              fifo_full_i,
  output logic              free_c,
  output logic              fifo_wr_en_o,
  output logic [WORD_W-1:0] fifo_wr_data_o
);

  logic              slot_vld;
  logic [WORD_W-1:0] slot_data;

  assign fifo_wr_en_o   = slot_vld & ~fifo_full_i;
  assign fifo_wr_data_o = slot_data;
  // A write draining the slot this cycle makes room for a same-cycle load.
  assign free_c         = ~slot_vld | fifo_wr_en_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_vld  <= 1'b0;
      slot_data <= '0;
    end else if (load_i && free_c) begin
      slot_vld  <= 1'b1;
      slot_data <= load_data_i;
    end else if (fifo_wr_en_o) begin
      slot_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/pmt_rx_word_packer.sv
// Packs the 32-bit Aurora receive stream into 128-bit DMA words, closing each
// frame with a padded partial word and a trailer carrying word/drop counts.
module pmt_rx_word_packer
  import pmt_pack_pkg::*;
#(
  parameter logic [31:0] PAD_WORD      = 32'h0000_0000,
  parameter logic [31:0] TRAILER_MAGIC = 32'hA5A5_5A5A
) (
  input  logic          aurora_clk_i,
  input  logic          aurora_rst_i,
  input  logic          pmt_aurora_rxen_i,
  input  logic [31:0]   pmt_aurora_rxdata_i,
  input  logic          pmt_rx_start_i,
  input  logic          pmt_rx_end_i,
  input  logic          fifo_full_i,
  output logic          fifo_wr_en_o,
  output logic [127:0]  fifo_wr_data_o,
  output logic          frame_busy_o,
  output logic          frame_done_o,
  output logic [31:0]   frame_word_cnt_o,
  output logic [15:0]   frame_drop_cnt_o,
  output logic          overflow_o
);

  state_t                             state, state_nxt;
  logic [LANE_W-1:0]                  lane_cnt, lane_cnt_nxt;
  logic [LANES-2:0][DATA_W-1:0]       part, part_nxt;
  logic [CNT_W-1:0]                   word_cnt, word_cnt_nxt;
  logic [DROP_W-1:0]                  drop_cnt, drop_cnt_nxt;
  logic                               overflow, overflow_nxt;
  logic [CNT_W-1:0]                   frame_idx, frame_idx_nxt;
  logic                               done, done_nxt;

  logic                               slot_free_c;
  logic                               slot_load_c;
  logic [WORD_W-1:0]                  slot_data_c;
  logic [WORD_W-1:0]                  pad_word_c;
  trailer_t                           trailer_c;

  pmt_pack_slot u_slot (
    .clk_i          (aurora_clk_i),
    .rst_i          (aurora_rst_i),
    .load_i         (slot_load_c),
    .load_data_i    (slot_data_c),
    .fifo_full_i    (fifo_full_i),
    .free_c         (slot_free_c),
    .fifo_wr_en_o   (fifo_wr_en_o),
    .fifo_wr_data_o (fifo_wr_data_o)
  );

  always_ff @(posedge aurora_clk_i) begin
    if (aurora_rst_i) begin
      state     <= IDLE;
      lane_cnt  <= '0;
      part      <= '0;
      word_cnt  <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      frame_idx <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      lane_cnt  <= lane_cnt_nxt;
      part      <= part_nxt;
      word_cnt  <= word_cnt_nxt;
      drop_cnt  <= drop_cnt_nxt;
      overflow  <= overflow_nxt;
      frame_idx <= frame_idx_nxt;
      done      <= done_nxt;
    end
  end

  // Closing words: lanes at or above the fill level carry the pad pattern.
  always_comb begin
    pad_word_c = '0;
    for (int i = 0; i < LANES - 1; i++) begin
      pad_word_c[i*DATA_W +: DATA_W] = (LANE_W'(i) < lane_cnt) ? part[i] : PAD_WORD;
    end
    pad_word_c[(LANES-1)*DATA_W +: DATA_W] = PAD_WORD;

    trailer_c           = '0;
    trailer_c.magic     = TRAILER_MAGIC;
    trailer_c.word_cnt  = word_cnt;
    trailer_c.drop_cnt  = drop_cnt;
    trailer_c.frame_idx = frame_idx;
  end

  always_comb begin
    state_nxt     = state;
    lane_cnt_nxt  = lane_cnt;
    part_nxt      = part;
    word_cnt_nxt  = word_cnt;
    drop_cnt_nxt  = drop_cnt;
    overflow_nxt  = overflow;
    frame_idx_nxt = frame_idx;
    done_nxt      = 1'b0;
    slot_load_c   = 1'b0;
    slot_data_c   = '0;

    if (pmt_rx_start_i) begin
      // Start overrides everything, including a coincident end.
      state_nxt    = RUN;
      lane_cnt_nxt = '0;
      part_nxt     = '0;
      word_cnt_nxt = '0;
      drop_cnt_nxt = '0;
      overflow_nxt = 1'b0;
      if (pmt_aurora_rxen_i) begin
        part_nxt[0]  = pmt_aurora_rxdata_i;
        lane_cnt_nxt = LANE_W'(1);
        word_cnt_nxt = CNT_W'(1);
      end
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          if (pmt_aurora_rxen_i) begin
            lane_cnt_nxt = lane_cnt + LANE_W'(1);
            word_cnt_nxt = word_cnt + CNT_W'(1);
            if (lane_cnt == LANE_W'(LANES - 1)) begin
              if (slot_free_c) begin
                slot_load_c = 1'b1;
                slot_data_c = {pmt_aurora_rxdata_i, part};
              end else begin
                drop_cnt_nxt = drop_add(drop_cnt, 3'd4);
                overflow_nxt = 1'b1;
              end
            end else begin
              for (int i = 0; i < LANES - 1; i++) begin
                if (lane_cnt == LANE_W'(i)) part_nxt[i] = pmt_aurora_rxdata_i;
              end
            end
          end
          if (pmt_rx_end_i) state_nxt = (lane_cnt_nxt != '0) ? PAD : TRAIL;
        end
        PAD: begin
          if (slot_free_c) begin
            slot_load_c = 1'b1;
            slot_data_c = pad_word_c;
            state_nxt   = TRAIL;
          end
        end
        TRAIL: begin
          if (slot_free_c) begin
            slot_load_c   = 1'b1;
            slot_data_c   = trailer_c;
            frame_idx_nxt = frame_idx + CNT_W'(1);
            done_nxt      = 1'b1;
            state_nxt     = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase

      // Words arriving while the frame is being closed cannot be accepted.
      if (pmt_aurora_rxen_i && (state == PAD || state == TRAIL)) begin
        drop_cnt_nxt = drop_add(drop_cnt, 3'd1);
        overflow_nxt = 1'b1;
      end
    end
  end

  assign frame_busy_o     = (state != IDLE);
  assign frame_done_o     = done;
  assign frame_word_cnt_o = word_cnt;
  assign frame_drop_cnt_o = drop_cnt;
  assign overflow_o       = overflow;

endmodule

// File: tb/tb_pmt_rx_word_packer.sv
// Bench for pmt_rx_word_packer: directed frame table, hand-written corner
// sequences, and random traffic, all checked every cycle against a queue model.
module tb_pmt_rx_word_packer;

  localparam logic [31:0] MAGIC = 32'hA5A5_5A5A;
  localparam logic [31:0] PADW  = 32'h0000_0000;

  logic         clk = 1'b0;
  logic         rst, rxen, start, rx_end, full;
  logic [31:0]  rxdata;
  logic         wr_en, busy, done, ovf;
  logic [127:0] wr_data;
  logic [31:0]  word_cnt;
  logic [15:0]  drop_cnt;

  always #5 clk = ~clk;

  pmt_rx_word_packer dut (
    .aurora_clk_i        (clk),
    .aurora_rst_i        (rst),
    .pmt_aurora_rxen_i   (rxen),
    .pmt_aurora_rxdata_i (rxdata),
    .pmt_rx_start_i      (start),
    .pmt_rx_end_i        (rx_end),
    .fifo_full_i         (full),
    .fifo_wr_en_o        (wr_en),
    .fifo_wr_data_o      (wr_data),
    .frame_busy_o        (busy),
    .frame_done_o        (done),
    .frame_word_cnt_o    (word_cnt),
    .frame_drop_cnt_o    (drop_cnt),
    .overflow_o          (ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] got_v, input logic [127:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got_v, exp_v);
    end
  endtask

  // Behavioural model: frame phase, queue of pending words, one held FIFO entry.
  int           m_phase;  // 0 idle, 1 collecting, 2 closing partial, 3 closing trailer
  logic [31:0]  m_words[$];
  logic [31:0]  m_wcnt, m_idx;
  int           m_dcnt;
  bit           m_ovf, m_done, m_held;
  logic [127:0] m_held_data;
  logic [127:0] got[$];
  int           done_seen;

  function automatic logic [127:0] trl(input logic [31:0] wc, input logic [15:0] dc,
                                       input logic [31:0] idx);
    return {MAGIC, wc, 16'h0000, dc, idx};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_words.delete(); m_wcnt = 0; m_idx = 0; m_dcnt = 0;
    m_ovf = 0; m_done = 0; m_held = 0; m_held_data = '0;
  endtask

  task automatic model_drop(input int n);
    m_dcnt = (m_dcnt + n > 65535) ? 65535 : m_dcnt + n;
    m_ovf  = 1;
  endtask

  task automatic model_step(input bit r, input bit s, input bit e, input bit v,
                            input logic [31:0] d, input bit f);
    bit wr, fr;
    logic [127:0] w;
    if (r) begin
      model_reset();
      return;
    end
    wr = m_held && !f;
    fr = !m_held || wr;
    if (wr) m_held = 0;
    m_done = 0;
    if (s) begin
      m_phase = 1; m_words.delete(); m_wcnt = 0; m_dcnt = 0; m_ovf = 0;
      if (v) begin
        m_words.push_back(d);
        m_wcnt = 1;
      end
    end else if (m_phase == 1) begin
      if (v) begin
        m_words.push_back(d);
        m_wcnt++;
        if (m_words.size() == 4) begin
          w = {m_words[3], m_words[2], m_words[1], m_words[0]};
          m_words.delete();
          if (fr) begin
            m_held = 1; m_held_data = w;
          end else begin
            model_drop(4);
          end
        end
      end
      if (e) m_phase = (m_words.size() != 0) ? 2 : 3;
    end else if (m_phase == 2) begin
      if (fr) begin
        w = {PADW, PADW, PADW, PADW};
        for (int i = 0; i < m_words.size(); i++) w[32*i +: 32] = m_words[i];
        m_held = 1; m_held_data = w; m_phase = 3;
      end
      if (v) model_drop(1);
    end else if (m_phase == 3) begin
      if (fr) begin
        m_held = 1; m_held_data = trl(m_wcnt, 16'(m_dcnt), m_idx);
        m_idx++; m_done = 1; m_phase = 0;
      end
      if (v) model_drop(1);
    end
  endtask

  // One clock: drive at the falling edge, compare 1 ns later, advance the model.
  task automatic cycle(input bit r, input bit s, input bit e, input bit v,
                       input logic [31:0] d, input bit f);
    rst = r; start = s; rx_end = e; rxen = v; rxdata = d; full = f;
    #1;
    check("wr_en", 128'(wr_en), 128'(m_held && !f));
    if (m_held && !f) check("wr_data", wr_data, m_held_data);
    check("busy", 128'(busy), 128'(m_phase != 0));
    check("done", 128'(done), 128'(m_done));
    check("word_cnt", 128'(word_cnt), 128'(m_wcnt));
    check("drop_cnt", 128'(drop_cnt), 128'(16'(m_dcnt)));
    check("overflow", 128'(ovf), 128'(m_ovf));
    if (wr_en) got.push_back(wr_data);
    if (done) done_seen++;
    model_step(r, s, e, v, d, f);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit f);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 32'h0, f);
  endtask

  task automatic send(input int n, input logic [31:0] base, input bit f);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 1, base + 32'(i), f);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 32'h0, 0);
    cycle(1, 0, 0, 0, 32'h0, 0);
    got.delete();
    done_seen = 0;
  endtask

  typedef struct {
    bit                 do_reset;
    int                 nwords;
    logic [31:0]        base;
    int                 nexp;
    logic [2:0][127:0]  exp;  // exp[0] is the first expected write
  } frame_vec_t;

  frame_vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 8, 32'h0, 3,
                {trl(32'd8, 16'd0, 32'd0),
                 128'h00000007_00000006_00000005_00000004,
                 128'h00000003_00000002_00000001_00000000}};
    vecs[1] = '{1'b1, 5, 32'h10, 3,
                {trl(32'd5, 16'd0, 32'd0),
                 128'h00000000_00000000_00000000_00000014,
                 128'h00000013_00000012_00000011_00000010}};
    vecs[2] = '{1'b1, 0, 32'h0, 1, {128'h0, 128'h0, trl(32'd0, 16'd0, 32'd0)}};
    vecs[3] = '{1'b0, 0, 32'h0, 1, {128'h0, 128'h0, trl(32'd0, 16'd0, 32'd1)}};
    vecs[4] = '{1'b0, 3, 32'hAA00, 2,
                {128'h0, trl(32'd3, 16'd0, 32'd2),
                 128'h00000000_0000AA02_0000AA01_0000AA00}};

    rst = 1; start = 0; rx_end = 0; rxen = 0; rxdata = '0; full = 0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 0;
    #1;
    check("rst_wr_en", 128'(wr_en), 128'(0));
    check("rst_wr_data", wr_data, 128'h0);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_word_cnt", 128'(word_cnt), 128'(0));
    check("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    check("rst_overflow", 128'(ovf), 128'(0));
    @(negedge clk);

    // Directed frames with spec-derived expected writes.
    for (int t = 0; t < 5; t++) begin
      if (vecs[t].do_reset) do_reset();
      got.delete();
      done_seen = 0;
      cycle(0, 1, 0, 0, 32'h0, 0);
      send(vecs[t].nwords, vecs[t].base, 0);
      cycle(0, 0, 1, 0, 32'h0, 0);
      idle(8, 0);
      check($sformatf("vec%0d_nwrites", t), 128'(got.size()), 128'(vecs[t].nexp));
      for (int k = 0; k < vecs[t].nexp && k < got.size(); k++)
        check($sformatf("vec%0d_write%0d", t, k), got[k], vecs[t].exp[k]);
      check($sformatf("vec%0d_done_pulses", t), 128'(done_seen), 128'(1));
    end

    // FIFO full across a 12-word frame: one word held, two dropped.
    do_reset();
    cycle(0, 1, 0, 0, 32'h0, 1);
    send(12, 32'h300, 1);
    cycle(0, 0, 1, 0, 32'h0, 1);
    idle(4, 1);
    check("full_no_writes", 128'(got.size()), 128'(0));
    check("full_drop_cnt", 128'(drop_cnt), 128'(16'd8));
    check("full_overflow", 128'(ovf), 128'(1));
    check("full_busy", 128'(busy), 128'(1));
    check("full_no_done", 128'(done_seen), 128'(0));
    idle(6, 0);
    check("full_nwrites", 128'(got.size()), 128'(2));
    if (got.size() == 2) begin
      check("full_held", got[0], 128'h00000303_00000302_00000301_00000300);
      check("full_trailer", got[1], trl(32'd12, 16'd8, 32'd0));
    end

    // Restart mid-frame discards the partial word of the aborted frame.
    do_reset();
    cycle(0, 1, 0, 0, 32'h0, 0);
    send(6, 32'h100, 0);
    cycle(0, 1, 0, 0, 32'h0, 0);
    send(4, 32'h200, 0);
    cycle(0, 0, 1, 0, 32'h0, 0);
    idle(8, 0);
    check("restart_nwrites", 128'(got.size()), 128'(3));
    if (got.size() == 3) begin
      check("restart_w0", got[0], 128'h00000103_00000102_00000101_00000100);
      check("restart_w1", got[1], 128'h00000203_00000202_00000201_00000200);
      check("restart_trl", got[2], trl(32'd4, 16'd0, 32'd0));
    end

    // Reset after three words: nothing leaks out, next frame is normal.
    do_reset();
    cycle(0, 1, 0, 0, 32'h0, 0);
    send(3, 32'h500, 0);
    cycle(1, 0, 0, 0, 32'h0, 0);
    #1;
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_word_cnt", 128'(word_cnt), 128'(0));
    check("midrst_wr_en", 128'(wr_en), 128'(0));
    @(negedge clk);
    idle(3, 0);
    check("midrst_no_writes", 128'(got.size()), 128'(0));
    cycle(0, 1, 0, 0, 32'h0, 0);
    send(4, 32'h400, 0);
    cycle(0, 0, 1, 0, 32'h0, 0);
    idle(6, 0);
    check("midrst_nwrites", 128'(got.size()), 128'(2));
    if (got.size() == 2) begin
      check("midrst_w0", got[0], 128'h00000403_00000402_00000401_00000400);
      check("midrst_trl", got[1], trl(32'd4, 16'd0, 32'd0));
    end

    // Random traffic with bursty back-pressure, checked cycle by cycle.
    begin
      bit f_state = 0;
      for (int c = 0; c < 4000; c++) begin
        bit r, s, e, v;
        if ($urandom_range(0, 7) == 0) f_state = ~f_state;
        r = ($urandom_range(0, 799) == 0);
        s = ($urandom_range(0, 49) == 0);
        e = ($urandom_range(0, 19) == 0);
        v = ($urandom_range(0, 3) != 0);
        cycle(r, s, e, v, $urandom, f_state);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
